// File: rtl/mld_15_7_tx_sequencer_if.sv
// Bundle of the sequencer's upstream word handshake, encoder control/return
// and serial code-stream signals.
interface mld_15_7_tx_sequencer_if #(
  parameter int unsigned K = 7
) ();
  logic [K-1:0] msg_data;
  logic         msg_valid;
  logic         msg_ready;
  logic         abort;
  logic         enc_clear;
  logic         enc_in;
  logic         enc_sel;
  logic         enc_out;
  logic         code_bit;
  logic         code_valid;
  logic         code_first;
  logic         code_last;
  logic [3:0]   bit_idx;
  logic [15:0]  words_sent;

  // Upstream source / encoder side.
  modport master (
    output msg_data, msg_valid, abort, enc_out,
    input  msg_ready, enc_clear, enc_in, enc_sel, code_bit, code_valid,
           code_first, code_last, bit_idx, words_sent
  );

  // Sequencer side.
  modport slave (
    input  msg_data, msg_valid, abort, enc_out,
    output msg_ready, enc_clear, enc_in, enc_sel, code_bit, code_valid,
           code_first, code_last, bit_idx, words_sent
  );
endinterface

// File: rtl/mld_15_7_tx_sequencer.sv
// Serialises a K-bit word into an external (N,K) encoder: one clear cycle,
// K information cycles, then N-K parity cycles, with framing and a word count.
module mld_15_7_tx_sequencer #(
  parameter int unsigned N         = 15,
  parameter int unsigned K         = 7,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  mld_15_7_tx_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StClear, StInfo, StParity} state_e;

  localparam logic [3:0] InfoLast   = 4'(K - 1);
  localparam logic [3:0] ParityLast = 4'(N - 1);

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [K-1:0]   shreg_q, shreg_d;
  logic [15:0]    words_q, words_d;

  logic at_last;
  logic ready;
  logic accept;
  logic enc_clear, enc_in, enc_sel, code_valid;

  assign at_last = (state_q == StParity) && (idx_q == ParityLast);
  assign accept  = bus.msg_valid && ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over everything except reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StClear;
      end
      StClear: begin
        state_d = bus.abort ? StIdle : StInfo;
      end
      StInfo: begin
        if (bus.abort)               state_d = StIdle;
        else if (idx_q == InfoLast)  state_d = StParity;
      end
      StParity: begin
        if (bus.abort)                state_d = StIdle;
        else if (idx_q == ParityLast) state_d = accept ? StClear : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    ready      = (state_q == StIdle) || (at_last && !bus.abort);
    enc_clear  = 1'b0;
    enc_sel    = 1'b0;
    enc_in     = 1'b0;
    code_valid = 1'b0;
    unique case (state_q)
      StClear: enc_clear = 1'b1;
      StInfo: begin
        code_valid = 1'b1;
        enc_in     = MSB_FIRST ? shreg_q[K-1] : shreg_q[0];
      end
      StParity: begin
        code_valid = 1'b1;
        enc_sel    = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next state: index restarts at 0 on leaving CLEAR and is held
  // at 0 whenever no codeword bit is on the wire.
  always_comb begin
    idx_d = '0;
    if ((state_d == StInfo || state_d == StParity) && state_q != StClear) begin
      idx_d = idx_q + 4'd1;
    end

    shreg_d = shreg_q;
    if (accept) begin
      shreg_d = bus.msg_data;
    end else if (state_q != StIdle && bus.abort) begin
      shreg_d = '0;
    end else if (state_q == StInfo) begin
      shreg_d = MSB_FIRST ? {shreg_q[K-2:0], 1'b0} : {1'b0, shreg_q[K-1:1]};
    end

    words_d = words_q;
    if (at_last && !bus.abort) begin
      words_d = words_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      shreg_q <= '0;
      words_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      words_q <= words_d;
    end
  end

  assign bus.msg_ready  = ready;
  assign bus.enc_clear  = enc_clear;
  assign bus.enc_in     = enc_in;
  assign bus.enc_sel    = enc_sel;
  assign bus.code_bit   = bus.enc_out;
  assign bus.code_valid = code_valid;
  assign bus.code_first = code_valid && (idx_q == 4'd0);
  assign bus.code_last  = code_valid && (idx_q == ParityLast);
  assign bus.bit_idx    = idx_q;
  assign bus.words_sent = words_q;

endmodule

// File: tb/tb_mld_15_7_tx_sequencer.sv
// Bench for mld_15_7_tx_sequencer: an MSB-first and an LSB-first instance share
// one stimulus stream and are checked every cycle against a phase-counter model.
module tb_mld_15_7_tx_sequencer;

  localparam int N = 15;
  localparam int K = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic [K-1:0] msg_data;
  logic         msg_valid;
  logic         abort;
  logic         enc_out = 1'b0;
  logic         chk_en = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  mld_15_7_tx_sequencer_if #(.K(K)) bus1 ();
  mld_15_7_tx_sequencer_if #(.K(K)) bus0 ();

  assign bus1.msg_data  = msg_data;
  assign bus1.msg_valid = msg_valid;
  assign bus1.abort     = abort;
  assign bus1.enc_out   = enc_out;
  assign bus0.msg_data  = msg_data;
  assign bus0.msg_valid = msg_valid;
  assign bus0.abort     = abort;
  assign bus0.enc_out   = enc_out;

  mld_15_7_tx_sequencer #(.N(N), .K(K), .MSB_FIRST(1'b1)) dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  mld_15_7_tx_sequencer #(.N(N), .K(K), .MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  // Encoder stand-in: an arbitrary serial stream the sequencer must pass through.
  always @(posedge clk) begin
    #1 enc_out = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: p_m = -1 idle, 0 = clear cycle, 1..N = codeword bit p_m-1.
  int           p_m    = -1;
  int           sent_m = 0;
  logic [K-1:0] word_m = '0;
  logic         ready_m;
  logic         acc_m;

  assign ready_m = (p_m < 0) || (p_m == N && !abort);
  assign acc_m   = msg_valid && ready_m;

  always @(posedge clk) begin
    if (reset) begin
      p_m    <= -1;
      sent_m <= 0;
      word_m <= '0;
    end else begin
      if (acc_m) word_m <= msg_data;
      if (p_m >= 0 && abort) begin
        p_m <= -1;
      end else if (p_m == N) begin
        sent_m <= (sent_m + 1) % 65536;
        p_m    <= acc_m ? 0 : -1;
      end else if (p_m >= 0) begin
        p_m <= p_m + 1;
      end else if (acc_m) begin
        p_m <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic info_e, par_e, valid_e, in1_e, in0_e;
      logic [15:0] idx_e;
      info_e  = (p_m >= 1) && (p_m <= K);
      par_e   = (p_m > K) && (p_m <= N);
      valid_e = info_e || par_e;
      idx_e   = valid_e ? 16'(p_m - 1) : 16'd0;
      in1_e   = 1'b0;
      in0_e   = 1'b0;
      if (info_e) begin
        in1_e = word_m[K - p_m];
        in0_e = word_m[p_m - 1];
      end
      chk("msg_ready",  16'(bus1.msg_ready),  16'(ready_m));
      chk("enc_clear",  16'(bus1.enc_clear),  16'(p_m == 0));
      chk("enc_sel",    16'(bus1.enc_sel),    16'(par_e));
      chk("enc_in_msb", 16'(bus1.enc_in),     16'(in1_e));
      chk("enc_in_lsb", 16'(bus0.enc_in),     16'(in0_e));
      chk("code_bit",   16'(bus1.code_bit),   16'(enc_out));
      chk("code_valid", 16'(bus1.code_valid), 16'(valid_e));
      chk("code_first", 16'(bus1.code_first), 16'(p_m == 1));
      chk("code_last",  16'(bus1.code_last),  16'(p_m == N));
      chk("bit_idx",    16'(bus1.bit_idx),    idx_e);
      chk("words_sent", bus1.words_sent,      16'(sent_m));
      chk("lsb_valid",  16'(bus0.code_valid), 16'(valid_e));
      chk("lsb_words",  bus0.words_sent,      16'(sent_m));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic sw_bits   [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic busy_bits [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held two cycles with a word on offer: nothing is accepted.
    reset = 1'b1; msg_valid = 1'b1; msg_data = 7'h55; abort = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_ready", 16'(bus1.msg_ready), 16'd1);
    chk("rst_clear", 16'(bus1.enc_clear), 16'd0);
    chk("rst_valid", 16'(bus1.code_valid), 16'd0);
    chk("rst_idx",   16'(bus1.bit_idx), 16'd0);
    chk("rst_words", bus1.words_sent, 16'd0);
    reset = 1'b0; msg_valid = 1'b0;
    tick();
    chk("rst_no_accept", 16'(bus1.enc_clear), 16'd0);

    // Single word 1101010.
    msg_valid = 1'b1; msg_data = 7'b1101010;
    tick();
    msg_valid = 1'b0;
    chk("sw_clear", 16'(bus1.enc_clear), 16'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("sw_info_bit", 16'(bus1.enc_in), 16'(sw_bits[i]));
      chk("sw_info_sel", 16'(bus1.enc_sel), 16'd0);
      if (i == 0) chk("sw_first", 16'(bus1.code_first), 16'd1);
    end
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("sw_par_sel", 16'(bus1.enc_sel), 16'd1);
      if (j == 7) chk("sw_last", 16'(bus1.code_last), 16'd1);
    end
    tick();
    chk("sw_words", bus1.words_sent, 16'd1);
    chk("sw_idle", 16'(bus1.code_valid), 16'd0);

    // Back-to-back: valid held, second word taken on the last parity cycle.
    msg_valid = 1'b1; msg_data = 7'b0110011;
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (c == 1) begin
        chk("b2b_clear1", 16'(bus1.enc_clear), 16'd1);
        msg_data = 7'b1011100;
      end
      if (c == 16) begin
        chk("b2b_last1", 16'(bus1.code_last), 16'd1);
        chk("b2b_ready", 16'(bus1.msg_ready), 16'd1);
      end
      if (c == 17) begin
        chk("b2b_clear2", 16'(bus1.enc_clear), 16'd1);
        msg_valid = 1'b0;
      end
      if (c == 18) chk("b2b_first2", 16'(bus1.code_first), 16'd1);
      if (c == 33) chk("b2b_words", bus1.words_sent, 16'd3);
    end

    // Busy: upstream wiggles during INFO must not disturb the word.
    msg_valid = 1'b1; msg_data = 7'b1000001;
    tick();
    msg_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("busy_bit", 16'(bus1.enc_in), 16'(busy_bits[i]));
      msg_valid = (i % 2) == 0;
      msg_data  = 7'($urandom);
      #1 chk("busy_ready", 16'(bus1.msg_ready), 16'd0);
    end
    msg_valid = 1'b0;
    for (int j = 0; j < 8; j++) tick();
    tick();
    chk("busy_words", bus1.words_sent, 16'd4);

    // Abort at bit 9, then a new word accepted while abort is high in IDLE.
    msg_valid = 1'b1; msg_data = 7'b0101101;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) msg_valid = 1'b0;
    end
    chk("abort_idx", 16'(bus1.bit_idx), 16'd9);
    abort = 1'b1; msg_valid = 1'b1;
    #1 chk("abort_ready", 16'(bus1.msg_ready), 16'd0);
    tick();
    chk("abort_idle_valid", 16'(bus1.code_valid), 16'd0);
    chk("abort_idle_idx", 16'(bus1.bit_idx), 16'd0);
    chk("abort_words", bus1.words_sent, 16'd4);
    msg_data = 7'b1110001;
    tick();
    chk("idle_abort_accept", 16'(bus1.enc_clear), 16'd1);
    abort = 1'b0; msg_valid = 1'b0;
    for (int c = 2; c <= 16; c++) tick();
    chk("abort_last_pos", 16'(bus1.code_last), 16'd1);
    abort = 1'b1; msg_valid = 1'b1;
    #1 chk("abort_last_ready", 16'(bus1.msg_ready), 16'd0);
    tick();
    abort = 1'b0; msg_valid = 1'b0;
    chk("abort_last_words", bus1.words_sent, 16'd4);
    chk("abort_last_noclr", 16'(bus1.enc_clear), 16'd0);

    // Bit ordering with a single set LSB.
    msg_valid = 1'b1; msg_data = 7'b0000001;
    tick();
    msg_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("lsb_order", 16'(bus0.enc_in), 16'(i == 0));
      chk("msb_order", 16'(bus1.enc_in), 16'(i == 6));
    end
    for (int j = 0; j < 8; j++) tick();
    tick();
    chk("order_words", bus1.words_sent, 16'd5);

    // Reset in the middle of a word.
    msg_valid = 1'b1; msg_data = 7'b1111111;
    tick();
    msg_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_words", bus1.words_sent, 16'd0);
    chk("mid_rst_valid", 16'(bus1.code_valid), 16'd0);
    chk("mid_rst_ready", 16'(bus1.msg_ready), 16'd1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mld_15_7_tx_sequencer.md
MLD_15_7_TX_SEQUENCER -- requirements
Module: mld_15_7_tx_sequencer

Interface
REQ-001 SHALL have parameter N, default 15, codeword length in bits.
REQ-002 SHALL have parameter K, default 7, information length in bits; N-K parity bits.
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = msg_data[K-1] serialized first, 0 = msg_data[0] first.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 msg_data  input  K  parallel information word; sampled only on accept.
REQ-007 msg_valid  input  1  upstream word available.
REQ-008 msg_ready  output  1  sequencer can accept a word this cycle.
REQ-009 abort  input  1  synchronous cancel of the word in flight.
REQ-010 enc_clear  output  1  one-cycle clear pulse to encoder shift register.
REQ-011 enc_in  output  1  serial information bit to encoder information_bit input.
REQ-012 enc_sel  output  1  encoder sel: 0 = information phase, 1 = parity phase.
REQ-013 enc_out  input  1  serial code bit from encoder out.
REQ-014 code_bit  output  1  combinational pass-through of enc_out.
REQ-015 code_valid  output  1  code_bit is a codeword bit this cycle.
REQ-016 code_first  output  1  high with bit 0 of a codeword.
REQ-017 code_last  output  1  high with bit N-1 of a codeword.
REQ-018 bit_idx  output  4  index of current codeword bit, 0..N-1; 0 outside INFO/PARITY.
REQ-019 words_sent  output  16  count of fully transmitted codewords.

Function
REQ-020 SHALL implement states IDLE, CLEAR, INFO, PARITY.
REQ-021 Accept SHALL occur when msg_valid && msg_ready at a rising edge; msg_data latched into a K-bit shift register.
REQ-022 msg_ready SHALL be 1 in IDLE, 1 in PARITY when bit_idx = N-1 and abort = 0, else 0.
REQ-023 IDLE -> CLEAR on accept; IDLE holds otherwise.
REQ-024 CLEAR SHALL last exactly one cycle with enc_clear = 1, enc_sel = 0, enc_in = 0, code_valid = 0; then -> INFO with bit_idx = 0.
REQ-025 INFO SHALL last K cycles, bit_idx 0..K-1, enc_sel = 0, enc_in = latched bit in order per MSB_FIRST; then -> PARITY.
REQ-026 PARITY SHALL last N-K cycles, bit_idx K..N-1, enc_sel = 1, enc_in = 0.
REQ-027 code_valid SHALL be 1 exactly in INFO and PARITY; code_first = code_valid && bit_idx = 0; code_last = code_valid && bit_idx = N-1.
REQ-028 At bit_idx = N-1: words_sent increments; next state CLEAR if accept same cycle, else IDLE.
REQ-029 Accept-to-first-bit latency SHALL be 2 cycles; back-to-back throughput SHALL be one codeword per N+1 cycles (one CLEAR gap).
REQ-030 msg_valid while msg_ready = 0 SHALL be ignored; msg_data not sampled.
REQ-031 abort in CLEAR/INFO/PARITY SHALL force IDLE next cycle, drop the word, leave words_sent unchanged, block same-cycle accept; abort in IDLE has no effect.
REQ-032 words_sent SHALL wrap 65535 -> 0.
REQ-033 enc_clear SHALL be 0 in all states other than CLEAR.

Reset
REQ-034 reset SHALL take priority over abort and accept; next state IDLE.
REQ-035 After reset: msg_ready = 1, enc_clear = 0, enc_in = 0, enc_sel = 0, code_valid = code_first = code_last = 0, bit_idx = 0, words_sent = 0, shift register = 0.
REQ-036 reset mid-word SHALL discard the word identically to abort, and zero words_sent.

Verification
REQ-037 Reset: assert reset 2 cycles with msg_valid = 1 -> all outputs per REQ-035, no accept.
REQ-038 Single word: msg_data = 7'b1101010 accepted at edge t -> enc_clear at t+1; enc_in = 1,1,0,1,0,1,0 at t+2..t+8 with enc_sel = 0; enc_sel = 1 at t+9..t+16; code_first at t+2, code_last at t+16; words_sent = 1; code_bit equals enc_out every cycle.
REQ-039 Back-to-back: msg_valid held, second word accepted at t+16 -> CLEAR at t+17, code_first at t+18, words_sent = 2 after t+32.
REQ-040 Busy: toggle msg_valid/msg_data during INFO -> msg_ready = 0, transmitted bits unchanged.
REQ-041 Abort at bit_idx = 9 -> IDLE next cycle, code_valid = 0, words_sent unchanged; next word transmits correctly from CLEAR.
REQ-042 MSB_FIRST = 0, msg_data = 7'b0000001 -> enc_in = 1 at bit_idx 0, 0 at bit_idx 1..6.
